toggle_event_decoder: RTL

// Receive end of a toggle-encoded event line, such as a T flip-flop Q output driven by T=1 strobes.

---
 rtl/toggle_event_decoder.sv | 96 +++++++++
 1 files changed

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event line.
// Synchronises the line, emits one pulse per transition and queues events for a consumer.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    input  logic                   Toggle_In,
    input  logic                   Event_Ready_In,
    input  logic                   Clear_In,
    output logic                   Level_Out,
    output logic                   Event_Pulse_Out,
    output logic                   Event_Valid_Out,
    output logic [COUNT_WIDTH-1:0] Pending_Count_Out,
    output logic                   Overflow_Out
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CountZero = '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   pulse_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   detect;
    logic                   pop;

    // Shift the raw line through the synchroniser; bit 0 is the first stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], Toggle_In};
    end

    assign Level_Out         = sync_q[SYNC_STAGES-1];
    assign detect            = Level_Out ^ prev_q;
    assign Event_Valid_Out   = (count_q != CountZero);
    assign pop               = Event_Valid_Out & Event_Ready_In;
    assign Event_Pulse_Out   = pulse_q;
    assign Pending_Count_Out = count_q;
    assign Overflow_Out      = ovf_q;

    // Pending-count and overflow next state; clear wins, a push and pop cancel.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Clear_In) begin
            count_d = detect ? CountOne : CountZero;
            ovf_d   = 1'b0;
        end else if (detect && pop) begin
            count_d = count_q;
        end else if (detect && (count_q == CountMax)) begin
            ovf_d   = 1'b1;
        end else if (detect) begin
            count_d = count_q + CountOne;
        end else if (pop) begin
            count_d = count_q - CountOne;
        end
    end

    // Synchroniser and edge-reference registers; reference level after reset is 0.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= Level_Out;
        end
    end

    // Registered event pulse, independent of counter state.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= detect;
        end
    end

    // Pending-event counter and sticky overflow flag.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
